// File: rtl/servo_pkg.sv
// servo_pkg: shared constants and helpers for the multi-channel servo pulse generator.
//   TICK_DIV_DEF / FRAME_TICKS_DEF / PW_MAX_DEF : default timebase and saturation values
//   cnt_w()  : bit width needed to hold 0..n_states-1 (minimum 1)
//   sat_pw() : clamp a signed command+trim sum into 0..pw_max ticks
package servo_pkg;

    localparam int unsigned TICK_DIV_DEF    = 32;
    localparam int unsigned FRAME_TICKS_DEF = 2048;
    localparam int unsigned PW_MAX_DEF      = 2047;

    // Width of a counter that runs 0..n_states-1.
    function automatic int unsigned cnt_w(input int unsigned n_states);
        return (n_states <= 2) ? 32'd1 : $clog2(n_states);
    endfunction

    // Saturate a signed sum to the legal pulse-width range.
    function automatic int unsigned sat_pw(input int signed sum, input int unsigned pw_max);
        if (sum < 0) return 32'd0;
        if ($unsigned(sum) > pw_max) return pw_max;
        return $unsigned(sum);
    endfunction

endpackage

// File: rtl/servo_timebase.sv
// servo_timebase: shared frame timebase (clock divider + tick counter).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   o_fs_c         : combinational frame-start condition (div_cnt==0 && tick_cnt==0)
//   o_tick_cnt     : current tick within the frame, 0..FRAME_TICKS-1
module servo_timebase
    import servo_pkg::*;
#(
    parameter int unsigned  TICK_DIV    = TICK_DIV_DEF,
    parameter int unsigned  FRAME_TICKS = FRAME_TICKS_DEF,
    localparam int unsigned TW          = cnt_w(FRAME_TICKS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    output logic          o_fs_c,
    output logic [TW-1:0] o_tick_cnt
);

    localparam int unsigned DW = cnt_w(TICK_DIV);

    logic [DW-1:0] r_div_cnt;
    logic [TW-1:0] r_tick_cnt;
    logic          w_div_wrap;

    assign w_div_wrap = (r_div_cnt == DW'(TICK_DIV - 1));

    // Divider and tick counter; tick advances once per divider wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
        end else begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + DW'(1);
            if (w_div_wrap) begin
                r_tick_cnt <= (r_tick_cnt == TW'(FRAME_TICKS - 1)) ? '0 : r_tick_cnt + TW'(1);
            end
        end
    end

    assign o_fs_c     = (r_div_cnt == '0) && (r_tick_cnt == '0);
    assign o_tick_cnt = r_tick_cnt;

endmodule

// File: rtl/servo_multi.sv
// servo_multi: N-channel servo/PWM pulse generator on one shared frame timebase.
// Commands are captured into shadow registers at any time and transferred, with the
// signed trim added and saturated, into the active width only at frame start.
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_enable        : global output enable, sampled at frame start
//   i_command       : unsigned command per channel, channel i at [i*CMD_W +: CMD_W]
//   i_cmd_valid     : per-channel strobe capturing the command slice into the shadow
//   i_offset        : signed trim per channel, same packing as i_command
//   o_servo         : registered pulse outputs
//   o_frame_start   : one-cycle pulse, one clock after the frame-start condition
//   o_failsafe      : per-channel failsafe flag (only when SERVO_FAILSAFE_EN is defined)
// Build option: SERVO_FAILSAFE_EN adds per-channel stale-command detection.
module servo_multi
    import servo_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned CMD_W           = 10,
    parameter int unsigned TICK_DIV        = TICK_DIV_DEF,
    parameter int unsigned FRAME_TICKS     = FRAME_TICKS_DEF,
    parameter int unsigned PW_MAX          = PW_MAX_DEF,
    parameter int unsigned FAILSAFE_FRAMES = 50,
    parameter int unsigned FAILSAFE_CMD    = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic [N_CH*CMD_W-1:0]   i_command,
    input  logic [N_CH-1:0]         i_cmd_valid,
    input  logic [N_CH*CMD_W-1:0]   i_offset,
    output logic [N_CH-1:0]         o_servo,
    output logic                    o_frame_start
`ifdef SERVO_FAILSAFE_EN
    ,
    output logic [N_CH-1:0]         o_failsafe
`endif
);

    localparam int unsigned TW   = cnt_w(FRAME_TICKS);
    localparam int unsigned PW_W = cnt_w(PW_MAX + 1);
    localparam int unsigned SW   = CMD_W + 2;

    // Elaboration-time parameter sanity.
    if (PW_MAX >= FRAME_TICKS) begin : g_chk_pw_max
        $error("servo_multi: PW_MAX must be below FRAME_TICKS");
    end
    if (TICK_DIV < 2) begin : g_chk_tick_div
        $error("servo_multi: TICK_DIV must be at least 2");
    end
    if ((FAILSAFE_FRAMES < 1) || (FAILSAFE_CMD >= (32'd1 << CMD_W))) begin : g_chk_failsafe
        $error("servo_multi: failsafe parameters out of range");
    end

    logic          w_fs;
    logic [TW-1:0] w_tick_cnt;
    logic          r_en_frame;
    logic          r_frame_start;
    logic          w_en_eff;

    servo_timebase #(
        .TICK_DIV    (TICK_DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_timebase (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .o_fs_c     (w_fs),
        .o_tick_cnt (w_tick_cnt)
    );

    // At frame start the outputs already use the freshly sampled enable.
    assign w_en_eff = w_fs ? i_enable : r_en_frame;

    // Frame enable latch and frame-start marker.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en_frame    <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            if (w_fs) r_en_frame <= i_enable;
            r_frame_start <= w_fs;
        end
    end

    assign o_frame_start = r_frame_start;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CMD_W-1:0]     r_shadow;
        logic [PW_W-1:0]      r_active_w;
        logic                 r_servo;
        logic [CMD_W-1:0]     w_off;
        logic signed [SW-1:0] w_sum;
        logic [PW_W-1:0]      w_width_new;
        logic [PW_W-1:0]      w_width_eff;

        // Zero-extended command plus sign-extended trim; two guard bits cannot overflow.
        assign w_off       = i_offset[gi*CMD_W +: CMD_W];
        assign w_sum       = $signed({2'b00, r_shadow}) + $signed({{2{w_off[CMD_W-1]}}, w_off});
        assign w_width_new = PW_W'(sat_pw(32'(w_sum), PW_MAX));
        assign w_width_eff = w_fs ? w_width_new : r_active_w;

        // Active width transfer and pulse generation.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_active_w <= '0;
                r_servo    <= 1'b0;
            end else begin
                if (w_fs) r_active_w <= w_width_new;
                r_servo <= w_en_eff && (w_tick_cnt < TW'(w_width_eff));
            end
        end

`ifdef SERVO_FAILSAFE_EN
        localparam int unsigned FW = cnt_w(FAILSAFE_FRAMES + 1);

        logic [FW-1:0] r_miss_cnt;
        logic          r_failsafe;

        // Shadow capture; a stale channel falls back to the failsafe command.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_shadow   <= '0;
                r_miss_cnt <= '0;
                r_failsafe <= 1'b0;
            end else if (i_cmd_valid[gi]) begin
                r_shadow   <= i_command[gi*CMD_W +: CMD_W];
                r_miss_cnt <= '0;
                r_failsafe <= 1'b0;
            end else if (w_fs && (r_miss_cnt < FW'(FAILSAFE_FRAMES))) begin
                r_miss_cnt <= r_miss_cnt + FW'(1);
                if (r_miss_cnt == FW'(FAILSAFE_FRAMES - 1)) begin
                    r_failsafe <= 1'b1;
                    r_shadow   <= CMD_W'(FAILSAFE_CMD);
                end
            end
        end

        assign o_failsafe[gi] = r_failsafe;
`else
        // Shadow capture; holds the last command indefinitely.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_shadow <= '0;
            end else if (i_cmd_valid[gi]) begin
                r_shadow <= i_command[gi*CMD_W +: CMD_W];
            end
        end
`endif

        assign o_servo[gi] = r_servo;
    end

endmodule

// File: tb/tb_servo_multi.sv
// tb_servo_multi: self-checking bench for servo_multi with a scaled-down timebase
// (4 clocks per tick, 128 ticks per frame, 100-tick ceiling). A clock-position model
// predicts every output each cycle; directed phases pin measured pulse widths, then a
// randomized phase runs against the same model. Works with or without SERVO_FAILSAFE_EN.
module tb_servo_multi;

    localparam int NCH  = 4;
    localparam int CW   = 10;
    localparam int TD   = 4;
    localparam int FT   = 128;
    localparam int PWM  = 100;
    localparam int FFR  = 3;
    localparam int FCMD = 48;
    localparam int FP   = TD * FT;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [NCH*CW-1:0] command;
    logic [NCH-1:0]    cmd_valid;
    logic [NCH*CW-1:0] offset;
    logic [NCH-1:0]    servo;
    logic              frame_start;
`ifdef SERVO_FAILSAFE_EN
    logic [NCH-1:0]    failsafe;
`endif

    servo_multi #(
        .N_CH            (NCH),
        .CMD_W           (CW),
        .TICK_DIV        (TD),
        .FRAME_TICKS     (FT),
        .PW_MAX          (PWM),
        .FAILSAFE_FRAMES (FFR),
        .FAILSAFE_CMD    (FCMD)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (enable),
        .i_command     (command),
        .i_cmd_valid   (cmd_valid),
        .i_offset      (offset),
        .o_servo       (servo),
        .o_frame_start (frame_start)
`ifdef SERVO_FAILSAFE_EN
        ,
        .o_failsafe    (failsafe)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             m_k;            // clock edges since reset release
    int             m_pos;
    int             m_shadow [NCH];
    int             m_w      [NCH];
    int             m_miss   [NCH];
    bit             m_en;
    logic [NCH-1:0] exp_servo;
    logic [NCH-1:0] exp_fail;
    logic           exp_fs;

    function automatic int cmd_of(input int ch);
        logic [CW-1:0] t;
        t = command[ch*CW +: CW];
        return int'(t);
    endfunction

    function automatic int off_of(input int ch);
        logic signed [CW-1:0] t;
        t = offset[ch*CW +: CW];
        return int'(t);
    endfunction

    function automatic int clampw(input int s);
        if (s < 0) return 0;
        if (s > PWM) return PWM;
        return s;
    endfunction

    initial begin
        m_k = 0; m_en = 0; exp_servo = '0; exp_fail = '0; exp_fs = 0;
        for (int i = 0; i < NCH; i++) begin m_shadow[i] = 0; m_w[i] = 0; m_miss[i] = 0; end
        forever begin
            @(posedge clk or negedge rst_n);
            if (rst_n !== 1'b1) begin
                m_k = 0; m_en = 0; exp_servo = '0; exp_fail = '0; exp_fs = 0;
                for (int i = 0; i < NCH; i++) begin m_shadow[i] = 0; m_w[i] = 0; m_miss[i] = 0; end
            end else begin
                m_pos = m_k % FP;
                if (m_pos == 0) begin
                    for (int i = 0; i < NCH; i++) m_w[i] = clampw(m_shadow[i] + off_of(i));
                    m_en = enable;
                end
                for (int i = 0; i < NCH; i++) exp_servo[i] = m_en && (m_pos < m_w[i] * TD);
                exp_fs = (m_pos == 0);
                for (int i = 0; i < NCH; i++) begin
                    if (cmd_valid[i]) begin
                        m_shadow[i] = cmd_of(i);
                        m_miss[i]   = 0;
                        exp_fail[i] = 1'b0;
                    end
`ifdef SERVO_FAILSAFE_EN
                    else if (m_pos == 0 && m_miss[i] < FFR) begin
                        m_miss[i]++;
                        if (m_miss[i] == FFR) begin
                            exp_fail[i] = 1'b1;
                            m_shadow[i] = FCMD;
                        end
                    end
`endif
                end
                m_k++;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
            check("servo", 32'(servo), 32'(exp_servo));
            check("frame_start", 32'(frame_start), 32'(exp_fs));
`ifdef SERVO_FAILSAFE_EN
            check("failsafe", 32'(failsafe), 32'(exp_fail));
`endif
        end
    end

    // ---------------- pulse-width / period monitor ----------------
    int hi      [NCH];
    int last_hi [NCH];
    int per;
    int last_period;

    initial forever begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
            for (int i = 0; i < NCH; i++) hi[i] = 0;
            per = 0;
        end else if (frame_start) begin
            for (int i = 0; i < NCH; i++) begin
                last_hi[i] = hi[i];
                hi[i]      = int'(servo[i]);
            end
            last_period = per;
            per = 1;
        end else begin
            for (int i = 0; i < NCH; i++) hi[i] += int'(servo[i]);
            per++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_to(input int target);
        while (m_k < target) @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input int cmd, input int off);
        command[ch*CW +: CW] = CW'(cmd);
        offset[ch*CW +: CW]  = CW'(off);
    endtask

    task automatic pulse_valid(input logic [NCH-1:0] mask);
        cmd_valid = mask;
        @(negedge clk);
        cmd_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int o;
        rst_n = 1'b0; enable = 1'b1; command = '0; cmd_valid = '0; offset = '0;
        repeat (3) @(negedge clk);
        check("reset_servo", 32'(servo), 32'd0);
        check("reset_frame_start", 32'(frame_start), 32'd0);
        rst_n = 1'b1;

        // ch0 25 -> 100 clk, ch1 3-5 -> 0, ch2 1023+1023 -> ceiling 400 clk, ch3 10 -> 40 clk
        run_to(5);
        set_ch(0, 25, 0); set_ch(1, 3, -5); set_ch(2, 1023, 1023); set_ch(3, 10, 0);
        pulse_valid(4'b1111);
        run_to(2*FP + 2);
        check("f1_ch0_width", 32'(last_hi[0]), 32'd100);
        check("f1_ch1_width", 32'(last_hi[1]), 32'd0);
        check("f1_ch2_width", 32'(last_hi[2]), 32'd400);
        check("f1_ch3_width", 32'(last_hi[3]), 32'd40);
        check("f1_period", 32'(last_period), 32'd512);

        // Mid-frame update, then an update landing exactly on the frame-start cycle.
        run_to(2*FP + 50*TD);
        set_ch(0, 50, 0);
        pulse_valid(4'b0001);
        run_to(3*FP);
        set_ch(0, 40, 0);
        pulse_valid(4'b0001);
        run_to(3*FP + 2);
        check("f2_ch0_keeps_old", 32'(last_hi[0]), 32'd100);
`ifdef SERVO_FAILSAFE_EN
        check("fs_flag_ch3_set", 32'(failsafe[3]), 32'd1);
        check("fs_flag_ch0_clear", 32'(failsafe[0]), 32'd0);
`endif
        run_to(4*FP + 2);
        check("f3_ch0_mid_update", 32'(last_hi[0]), 32'd200);
        run_to(5*FP + 2);
        check("f4_ch0_fs_update", 32'(last_hi[0]), 32'd160);
`ifdef SERVO_FAILSAFE_EN
        check("f4_ch3_failsafe_width", 32'(last_hi[3]), 32'd192);
        set_ch(3, 10, 0);
        pulse_valid(4'b1000);
        check("fs_flag_ch3_cleared", 32'(failsafe[3]), 32'd0);
`else
        check("f4_ch3_held_width", 32'(last_hi[3]), 32'd40);
`endif

        // Enable dropped at tick 10 of frame 5, restored during frame 6.
        run_to(5*FP + 10*TD);
        enable = 1'b0;
        run_to(6*FP + 2);
        check("f5_ch0_completes", 32'(last_hi[0]), 32'd160);
        run_to(6*FP + 28);
        enable = 1'b1;
        run_to(7*FP + 2);
        check("f6_all_low", 32'(last_hi[0] + last_hi[1] + last_hi[2] + last_hi[3]), 32'd0);
        run_to(8*FP + 2);
`ifdef SERVO_FAILSAFE_EN
        check("f7_ch0_resumes", 32'(last_hi[0]), 32'd192);
`else
        check("f7_ch0_resumes", 32'(last_hi[0]), 32'd160);
`endif

        // Asynchronous reset in the middle of a pulse.
        run_to(8*FP + 120);
        @(posedge clk);
        #1;
        check("pulse_before_reset", 32'(servo[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("servo_async_reset", 32'(servo), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_to(FP + 2);
        check("post_reset_width0", 32'(last_hi[0]), 32'd0);
        check("post_reset_period", 32'(last_period), 32'd512);

        // Randomized traffic against the model.
        for (int c = 0; c < 20*FP; c++) begin
            for (int i = 0; i < NCH; i++) begin
                command[i*CW +: CW] = ($urandom_range(0, 15) == 0) ? CW'(1023) : CW'($urandom_range(0, 130));
                if ($urandom_range(0, 499) == 0) begin
                    o = int'($urandom_range(0, 255)) - 128;
                    offset[i*CW +: CW] = CW'(o);
                end
            end
            for (int i = 0; i < NCH - 1; i++) cmd_valid[i] = ($urandom_range(0, 99) < 2);
            cmd_valid[NCH-1] = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 699) == 0) enable = ~enable;
            @(negedge clk);
        end
        cmd_valid = '0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
